// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Grants one requester at a time and drives the memory handshake.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4,
    parameter int CNT_W        = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic                i_flush,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_ack,
    output logic                i_stall,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ack,
    output logic                d_stall,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ready,
    output logic [CNT_W-1:0]    conflict_cnt
);

    localparam int BE_W = DATA_W / 8;
    localparam int SW   = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    typedef enum logic [2:0] {
        IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D
    } state_t;

    state_t            state, next;
    logic              grant_i, grant_d;
    logic [SW-1:0]     streak;
    logic              cancel;
    logic              lat_we;
    logic [BE_W-1:0]   lat_be;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    always_comb begin
        next    = state;
        grant_i = 1'b0;
        grant_d = 1'b0;
        unique case (state)
            IDLE: begin
                // Data wins ties until it has starved fetch for MAX_D_STREAK grants
                if (d_req && (!i_req || streak != STREAK_MAX)) begin
                    grant_d = 1'b1;
                    next    = BUSY_D;
                end else if (i_req) begin
                    grant_i = 1'b1;
                    next    = BUSY_I;
                end
            end
            BUSY_I: if (mem_ready) next = RESP_I;
            BUSY_D: if (mem_ready) next = RESP_D;
            RESP_I: next = IDLE;
            RESP_D: next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            streak    <= '0;
            lat_we    <= 1'b0;
            lat_be    <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (grant_d) begin
            if (streak != STREAK_MAX) streak <= streak + 1'b1;
            lat_we    <= d_we;
            lat_be    <= d_be;
            lat_addr  <= d_addr;
            lat_wdata <= d_wdata;
        end else if (grant_i) begin
            streak    <= '0;
            lat_we    <= 1'b0;
            lat_be    <= '1;
            lat_addr  <= i_addr;
            lat_wdata <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cancel  <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            if (state == BUSY_I && i_flush) cancel <= 1'b1;
            else if (state == RESP_I)       cancel <= 1'b0;
            if (state == BUSY_I && mem_ready && !cancel && !i_flush)
                i_rdata <= mem_rdata;
            if (state == BUSY_D && mem_ready && !lat_we)
                d_rdata <= mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            conflict_cnt <= '0;
        else if (state == IDLE && i_req && d_req && conflict_cnt != '1)
            conflict_cnt <= conflict_cnt + 1'b1;
    end

    assign mem_req   = (state == BUSY_I) || (state == BUSY_D);
    assign mem_we    = mem_req & lat_we;
    assign mem_be    = lat_be;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;

    assign i_ack   = (state == RESP_I) && !cancel && !i_flush;
    assign d_ack   = (state == RESP_D);
    assign i_stall = i_req & ~i_ack;
    assign d_stall = d_req & ~d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Each task drives one scenario and checks outputs 1ns after the clock edge.
module tb_mem_port_arbiter;

    localparam logic [31:0] I_RD2  = 32'h1111_1111;
    localparam logic [31:0] D_ADDR = 32'h0000_2000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_flush = 1'b0;
    logic [31:0] i_rdata;
    logic        i_ack, i_stall;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [3:0]  d_be = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_ack, d_stall;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic [15:0] conflict_cnt;

    int n_total = 0;
    int n_pass  = 0;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
        .i_rdata(i_rdata), .i_ack(i_ack), .i_stall(i_stall),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
        .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Gathers n grants (1 = data, 0 = instruction); mem_ready must be high
    task automatic collect_grants(input int n, output logic [15:0] seq,
                                  output int got);
        seq = '0;
        got = 0;
        for (int c = 0; c < 8 * n && got < n; c++) begin
            tick();
            if (mem_req) begin
                seq[got] = (mem_addr == D_ADDR);
                got++;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        n_total++;
        if (mem_req !== 1'b0 || i_ack !== 1'b0 || d_ack !== 1'b0)
            $display("FAIL reset_ctl: req/iack/dack=%b%b%b want 000",
                     mem_req, i_ack, d_ack);
        else n_pass++;
        n_total++;
        if (i_rdata !== 32'h0 || d_rdata !== 32'h0 || conflict_cnt !== 16'h0)
            $display("FAIL reset_data: i=%h d=%h cnt=%0d want 0",
                     i_rdata, d_rdata, conflict_cnt);
        else n_pass++;
    endtask

    task automatic test_fetch;
        i_addr = 32'h100;
        mem_rdata = 32'h0050_0093;
        mem_ready = 1'b1;
        i_req = 1'b1;
        #1;
        n_total++;
        if (i_stall !== 1'b1) $display("FAIL fetch_stall0: got %b want 1", i_stall);
        else n_pass++;
        tick();
        n_total++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100)
            $display("FAIL fetch_memreq: req=%b addr=%h want 1 100", mem_req, mem_addr);
        else n_pass++;
        n_total++;
        if (mem_we !== 1'b0 || mem_be !== 4'hF)
            $display("FAIL fetch_attr: we=%b be=%h want 0 f", mem_we, mem_be);
        else n_pass++;
        tick();
        n_total++;
        if (i_ack !== 1'b1 || i_rdata !== 32'h0050_0093)
            $display("FAIL fetch_ack: ack=%b data=%h want 1 00500093", i_ack, i_rdata);
        else n_pass++;
        n_total++;
        if (i_stall !== 1'b0) $display("FAIL fetch_stall1: got %b want 0", i_stall);
        else n_pass++;
        i_req = 1'b0;
        tick();
        n_total++;
        if (i_ack !== 1'b0 || mem_req !== 1'b0)
            $display("FAIL fetch_idle: ack=%b req=%b want 0 0", i_ack, mem_req);
        else n_pass++;
    endtask

    task automatic test_grant_order;
        logic [15:0] seq;
        int got;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        i_addr = 32'h100;
        d_addr = D_ADDR;
        d_we = 1'b0;
        mem_rdata = I_RD2;
        mem_ready = 1'b1;
        i_req = 1'b1;
        d_req = 1'b1;
        collect_grants(10, seq, got);
        n_total++;
        if (got != 10 || seq[9:0] !== 10'h1EF)
            $display("FAIL grant_order: got %0d grants seq=%b want 10 grants 0111101111",
                     got, seq[9:0]);
        else n_pass++;
        n_total++;
        if (conflict_cnt !== 16'd10)
            $display("FAIL conflict_cnt: got %0d want 10", conflict_cnt);
        else n_pass++;
        tick();
        i_req = 1'b0;
        d_req = 1'b0;
        tick();
    endtask

    task automatic test_load_wait;
        mem_ready = 1'b0;
        mem_rdata = 32'hCAFE_F00D;
        d_addr = D_ADDR;
        d_we = 1'b0;
        d_req = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            n_total++;
            if (mem_req !== 1'b1 || mem_addr !== D_ADDR || d_ack !== 1'b0)
                $display("FAIL load_wait%0d: req=%b addr=%h ack=%b want 1 2000 0",
                         k, mem_req, mem_addr, d_ack);
            else n_pass++;
            if (k == 3) mem_ready = 1'b1;
            tick();
        end
        n_total++;
        if (d_ack !== 1'b1 || d_rdata !== 32'hCAFE_F00D)
            $display("FAIL load_ack: ack=%b data=%h want 1 cafef00d", d_ack, d_rdata);
        else n_pass++;
        d_req = 1'b0;
        mem_ready = 1'b0;
        tick();
        n_total++;
        if (d_ack !== 1'b0) $display("FAIL load_ack_pulse: got %b want 0", d_ack);
        else n_pass++;
    endtask

    task automatic test_store;
        d_we = 1'b1;
        d_be = 4'b0011;
        d_addr = 32'h0000_3000;
        d_wdata = 32'hDEAD_BEEF;
        mem_rdata = 32'h5555_5555;
        mem_ready = 1'b1;
        d_req = 1'b1;
        tick();
        n_total++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b0011)
            $display("FAIL store_ctl: req=%b we=%b be=%b want 1 1 0011",
                     mem_req, mem_we, mem_be);
        else n_pass++;
        n_total++;
        if (mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h3000)
            $display("FAIL store_data: wdata=%h addr=%h want deadbeef 3000",
                     mem_wdata, mem_addr);
        else n_pass++;
        tick();
        n_total++;
        if (d_ack !== 1'b1 || d_rdata !== 32'hCAFE_F00D)
            $display("FAIL store_ack: ack=%b rdata=%h want 1 cafef00d", d_ack, d_rdata);
        else n_pass++;
        d_req = 1'b0;
        d_we = 1'b0;
        tick();
    endtask

    task automatic test_flush;
        i_addr = 32'h200;
        mem_ready = 1'b0;
        i_req = 1'b1;
        tick();
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        n_total++;
        if (mem_req !== 1'b1) $display("FAIL flush_busy: req=%b want 1", mem_req);
        else n_pass++;
        tick();
        n_total++;
        if (i_ack !== 1'b0 || i_rdata !== I_RD2)
            $display("FAIL flush_cancel: ack=%b data=%h want 0 11111111", i_ack, i_rdata);
        else n_pass++;
        n_total++;
        if (i_stall !== 1'b1) $display("FAIL flush_stall: got %b want 1", i_stall);
        else n_pass++;
        i_req = 1'b0;
        tick();
        i_addr = 32'h104;
        mem_rdata = 32'h1234_5678;
        i_req = 1'b1;
        tick();
        n_total++;
        if (mem_addr !== 32'h104) $display("FAIL refetch_addr: got %h want 104", mem_addr);
        else n_pass++;
        tick();
        n_total++;
        if (i_ack !== 1'b1 || i_rdata !== 32'h1234_5678)
            $display("FAIL refetch_ack: ack=%b data=%h want 1 12345678", i_ack, i_rdata);
        else n_pass++;
        i_req = 1'b0;
        tick();
        i_req = 1'b1;
        tick();
        tick();
        i_flush = 1'b1;
        #1;
        n_total++;
        if (i_ack !== 1'b0) $display("FAIL resp_flush: ack=%b want 0", i_ack);
        else n_pass++;
        i_req = 1'b0;
        tick();
        i_flush = 1'b0;
    endtask

    task automatic test_reset_busy;
        logic [15:0] seq;
        int got;
        mem_ready = 1'b0;
        d_addr = D_ADDR;
        d_req = 1'b1;
        tick();
        n_total++;
        if (mem_req !== 1'b1 || conflict_cnt === 16'h0)
            $display("FAIL pre_reset: req=%b cnt=%0d want 1 nonzero", mem_req, conflict_cnt);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_total++;
        if (mem_req !== 1'b0 || conflict_cnt !== 16'h0)
            $display("FAIL async_reset: req=%b cnt=%0d want 0 0", mem_req, conflict_cnt);
        else n_pass++;
        tick();
        reset = 1'b0;
        mem_ready = 1'b1;
        i_req = 1'b1;
        collect_grants(5, seq, got);
        n_total++;
        if (got != 5 || seq[4:0] !== 5'b01111)
            $display("FAIL streak_reset: got %0d grants seq=%b want 5 grants 01111",
                     got, seq[4:0]);
        else n_pass++;
        n_total++;
        if (conflict_cnt !== 16'd5)
            $display("FAIL cnt_after_reset: got %0d want 5", conflict_cnt);
        else n_pass++;
        i_req = 1'b0;
        d_req = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_grant_order();
        test_load_wait();
        test_store();
        test_flush();
        test_reset_busy();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: sim time exceeded");
        $fatal(1);
    end

endmodule
